// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD lap timer: FSM states, digit limits, mm:ss.cc layout.
// Pure declarations; no latency or flow control of its own.
package timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_PAUSE,
      ST_DONE
   } state_t;

   localparam logic [3:0] DIG_MAX9 = 4'd9;
   localparam logic [3:0] DIG_MAX5 = 4'd5;

   typedef struct packed {
      logic [3:0] min_h;
      logic [3:0] min_l;
      logic [3:0] sec_h;
      logic [3:0] sec_l;
      logic [3:0] cs_h;
      logic [3:0] cs_l;
   } bcd_time_t;

   localparam bcd_time_t T_MAX  = 24'h595999;
   localparam bcd_time_t T_ZERO = 24'h000000;
   localparam bcd_time_t T_ONE  = 24'h000001;

   function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
      return (d > max) ? max : d;
   endfunction

   // Out-of-range digits saturate individually rather than rejecting the whole load.
   function automatic bcd_time_t clamp_time(input bcd_time_t t);
      bcd_time_t r;
      r.min_h = clamp_digit(t.min_h, DIG_MAX5);
      r.min_l = clamp_digit(t.min_l, DIG_MAX9);
      r.sec_h = clamp_digit(t.sec_h, DIG_MAX5);
      r.sec_l = clamp_digit(t.sec_l, DIG_MAX9);
      r.cs_h  = clamp_digit(t.cs_h,  DIG_MAX9);
      r.cs_l  = clamp_digit(t.cs_l,  DIG_MAX9);
      return r;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One up/down BCD digit wrapping at MAX; combinational carry/borrow out for same-cycle ripple.
// Load wins over count; q updates one cycle after en/ld, no backpressure.
module bcd_digit #(
   parameter logic [3:0] MAX = 4'd9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       dn,
   input  logic       ld,
   input  logic [3:0] ld_val,
   output logic [3:0] q,
   output logic       co
);

   assign co = en & (dn ? (q == 4'd0) : (q == MAX));

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= 4'd0;
      end else if (ld) begin
         q <= ld_val;
      end else if (en) begin
         if (dn) begin
            q <= (q == 4'd0) ? MAX : q - 4'd1;
         end else begin
            q <= (q == MAX) ? 4'd0 : q + 4'd1;
         end
      end
   end

endmodule

// File: rtl/lap_timer.sv
// BCD mm:ss.cc stopwatch/countdown with limit detection and a lap-snapshot FIFO.
// Commands act on the next edge; count steps every CLK_DIV cycles in RUN; full FIFO drops laps (sticky lap_ovf).
module lap_timer
   import timer_pkg::*;
#(
   parameter int CLK_DIV   = 1_000_000,
   parameter int LAP_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        stop,
   input  logic        clr,
   input  logic        ld,
   input  logic        dir,
   input  logic [23:0] load_data,
   input  logic        lap,
   input  logic        lap_rd,
   output logic [23:0] count,
   output logic        running,
   output logic        done,
   output logic [23:0] lap_data,
   output logic        lap_valid,
   output logic        lap_full,
   output logic        lap_ovf
);

   localparam int LAP_AW = $clog2(LAP_DEPTH);
   localparam int PW     = $clog2(CLK_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

   state_t          state_q, state_d;
   logic            dir_q;
   logic [PW-1:0]   presc_q;
   logic [23:0]     cnt_q;

   logic            in_run, tick, ld_go, start_go, wrap, limit_go;
   logic [5:0]      dig_en, dig_co;
   logic            dig_ld;
   bcd_time_t       dig_ld_val;

   assign in_run   = (state_q == ST_RUN);
   assign tick     = in_run && (presc_q == PRESC_LAST);
   assign ld_go    = ld && !clr && !in_run;
   assign start_go = start && !clr && !ld_go && (state_q == ST_IDLE || state_q == ST_PAUSE);

   // A carry out of the top digit means the count tried to pass a limit: reload the limit instead.
   assign wrap     = dig_co[5];
   assign limit_go = wrap || (tick && dir_q && (cnt_q == T_ONE));

   assign dig_en = {dig_co[4:0], tick};
   assign dig_ld = clr || ld_go || wrap;

   always_comb begin
      dig_ld_val = T_ZERO;
      if (clr) begin
         dig_ld_val = T_ZERO;
      end else if (ld_go) begin
         dig_ld_val = clamp_time(load_data);
      end else if (!dir_q) begin
         dig_ld_val = T_MAX;
      end
   end

   for (genvar i = 0; i < 6; i++) begin : g_dig
      localparam logic [3:0] DMAX = (i == 3 || i == 5) ? DIG_MAX5 : DIG_MAX9;
      bcd_digit #(.MAX(DMAX)) u_dig (
         .clk    (clk),
         .rst    (rst),
         .en     (dig_en[i]),
         .dn     (dir_q),
         .ld     (dig_ld),
         .ld_val (dig_ld_val[4*i +: 4]),
         .q      (cnt_q[4*i +: 4]),
         .co     (dig_co[i])
      );
   end

   always_comb begin
      state_d = state_q;
      if (clr) begin
         state_d = ST_IDLE;
      end else if (ld_go) begin
         state_d = (state_q == ST_DONE) ? ST_IDLE : state_q;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (limit_go) begin
                  state_d = ST_DONE;
               end else if (stop) begin
                  state_d = ST_PAUSE;
               end
            end
            ST_IDLE, ST_PAUSE: begin
               if (start_go) begin
                  state_d = ST_RUN;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         dir_q   <= 1'b0;
         presc_q <= '0;
      end else begin
         state_q <= state_d;
         if (start_go) begin
            dir_q <= dir;
         end
         if (clr || ld_go) begin
            presc_q <= '0;
         end else if (in_run) begin
            presc_q <= tick ? '0 : presc_q + PW'(1);
         end
      end
   end

   assign count   = cnt_q;
   assign running = (state_q == ST_RUN);
   assign done    = (state_q == ST_DONE);

   logic [23:0]       lap_mem [LAP_DEPTH];
   logic [LAP_AW-1:0] wr_ptr, rd_ptr, rd_nxt;
   logic [LAP_AW:0]   fill_q, fill_d;
   logic [23:0]       lap_dat_q, head_nxt;
   logic              ovf_q;
   logic              push_vld, pop_vld, fifo_full, push_ok, push_drop;

   assign fifo_full = (fill_q == (LAP_AW+1)'(LAP_DEPTH));
   assign push_vld  = lap && !clr && (state_q == ST_RUN || state_q == ST_PAUSE);
   assign pop_vld   = lap_rd && !clr && (fill_q != '0);
   assign push_ok   = push_vld && (!fifo_full || pop_vld);
   assign push_drop = push_vld && fifo_full && !pop_vld;
   assign rd_nxt    = pop_vld ? rd_ptr + LAP_AW'(1) : rd_ptr;
   assign fill_d    = fill_q + (LAP_AW+1)'(push_ok) - (LAP_AW+1)'(pop_vld);

   // Head after this edge: the entry being pushed if the queue was otherwise drained.
   always_comb begin
      head_nxt = 24'd0;
      if (fill_d != '0) begin
         head_nxt = (push_ok && rd_nxt == wr_ptr) ? cnt_q : lap_mem[rd_nxt];
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         lap_mem[wr_ptr] <= cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fill_q    <= '0;
         lap_dat_q <= 24'd0;
         ovf_q     <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + LAP_AW'(1);
         end
         rd_ptr    <= rd_nxt;
         fill_q    <= fill_d;
         lap_dat_q <= head_nxt;
         if (push_drop) begin
            ovf_q <= 1'b1;
         end
      end
   end

   assign lap_data  = lap_dat_q;
   assign lap_valid = (fill_q != '0);
   assign lap_full  = fifo_full;
   assign lap_ovf   = ovf_q;

endmodule

// File: tb/tb_lap_timer.sv
// Bench for lap_timer: centisecond-integer reference model checked every cycle, plus fixed scenarios.
`timescale 1ns/1ps
module tb_lap_timer;

   localparam int CLK_DIV = 4;
   localparam int DEPTH   = 4;
   localparam int LAST_CS = 359999;
   localparam int MI = 0, MR = 1, MP = 2, MD = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0, stop = 1'b0, clr = 1'b0, ld = 1'b0, dir = 1'b0;
   logic        lap = 1'b0, lap_rd = 1'b0;
   logic [23:0] load_data = 24'd0;
   logic [23:0] count, lap_data;
   logic        running, done, lap_valid, lap_full, lap_ovf;

   lap_timer #(.CLK_DIV(CLK_DIV), .LAP_DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .clr       (clr),
      .ld        (ld),
      .dir       (dir),
      .load_data (load_data),
      .lap       (lap),
      .lap_rd    (lap_rd),
      .count     (count),
      .running   (running),
      .done      (done),
      .lap_data  (lap_data),
      .lap_valid (lap_valid),
      .lap_full  (lap_full),
      .lap_ovf   (lap_ovf)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   int          m_cs = 0, m_presc = 0, m_mode = MI;
   bit          m_down = 1'b0, m_ovf = 1'b0, m_lap_ok;
   logic [23:0] m_fifo [$];
   logic [23:0] m_snap;

   function automatic logic [23:0] to_bcd(input int cs);
      int m, s, c;
      m = cs / 6000;
      s = (cs / 100) % 60;
      c = cs % 100;
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
   endfunction

   function automatic int from_load(input logic [23:0] v);
      int d [6];
      int mx;
      for (int i = 0; i < 6; i++) begin
         mx   = (i == 3 || i == 5) ? 5 : 9;
         d[i] = int'(v[4*i +: 4]);
         if (d[i] > mx) d[i] = mx;
      end
      return ((d[5] * 10 + d[4]) * 60 + d[3] * 10 + d[2]) * 100 + d[1] * 10 + d[0];
   endfunction

   task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      if (rst) begin
         m_cs = 0; m_presc = 0; m_mode = MI; m_down = 1'b0; m_ovf = 1'b0;
         m_fifo.delete();
      end else begin
         m_snap   = to_bcd(m_cs);
         m_lap_ok = lap && (m_mode == MR || m_mode == MP);
         if (clr) begin
            m_fifo.delete();
            m_ovf = 1'b0;
         end else begin
            if (lap_rd && m_fifo.size() > 0) void'(m_fifo.pop_front());
            if (m_lap_ok) begin
               if (m_fifo.size() < DEPTH) m_fifo.push_back(m_snap);
               else m_ovf = 1'b1;
            end
         end
         if (clr) begin
            m_cs = 0; m_presc = 0; m_mode = MI;
         end else if (ld && m_mode != MR) begin
            m_cs = from_load(load_data);
            m_presc = 0;
            if (m_mode == MD) m_mode = MI;
         end else if (m_mode == MR) begin
            if (m_presc == CLK_DIV - 1) begin
               m_presc = 0;
               if (!m_down) begin
                  if (m_cs == LAST_CS) m_mode = MD;
                  else m_cs = m_cs + 1;
               end else if (m_cs == 0) begin
                  m_mode = MD;
               end else begin
                  m_cs = m_cs - 1;
                  if (m_cs == 0) m_mode = MD;
               end
            end else begin
               m_presc = m_presc + 1;
            end
            if (m_mode == MR && stop) m_mode = MP;
         end else if (start && m_mode != MD) begin
            m_mode = MR;
            m_down = dir;
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("count", count, to_bcd(m_cs));
         chk("running", {23'd0, running}, {23'd0, m_mode == MR});
         chk("done", {23'd0, done}, {23'd0, m_mode == MD});
         chk("lap_valid", {23'd0, lap_valid}, {23'd0, m_fifo.size() > 0});
         chk("lap_full", {23'd0, lap_full}, {23'd0, m_fifo.size() == DEPTH});
         chk("lap_data", lap_data, (m_fifo.size() > 0) ? m_fifo[0] : 24'd0);
         chk("lap_ovf", {23'd0, lap_ovf}, {23'd0, m_ovf});
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   logic [23:0] lap_exp [4] = '{24'h000005, 24'h000010, 24'h000015, 24'h000020};
   int          saved_cs, rem;

   initial begin
      @(negedge clk);
      cycles(2);
      #1;
      chk("rst_count", count, 24'd0);
      chk("rst_flags", {18'd0, running, done, lap_valid, lap_full, lap_ovf, 1'b0}, 24'd0);
      chk("rst_lap_data", lap_data, 24'd0);
      rst = 1'b0;
      chk_en = 1'b1;

      // free-running up count
      start = 1'b1; dir = 1'b0; cycles(1); start = 1'b0;
      cycles(400); #1;
      chk("up_400", count, 24'h000100);
      chk("up_running", {23'd0, running}, 24'd1);

      // lap capture with overflow, then readout
      clr = 1'b1; cycles(1); clr = 1'b0;
      start = 1'b1; dir = 1'b0; cycles(1); start = 1'b0;
      cycles(20);
      for (int k = 0; k < 5; k++) begin
         lap = 1'b1; cycles(1); lap = 1'b0; cycles(19);
      end
      #1;
      chk("lap_full_5", {23'd0, lap_full}, 24'd1);
      chk("lap_ovf_5", {23'd0, lap_ovf}, 24'd1);
      for (int k = 0; k < 4; k++) begin
         chk("lap_rd_head", lap_data, lap_exp[k]);
         lap_rd = 1'b1; cycles(1); lap_rd = 1'b0;
      end
      #1;
      chk("lap_drained", {23'd0, lap_valid}, 24'd0);

      // pause keeps count and prescaler phase
      stop = 1'b1; cycles(1); stop = 1'b0;
      saved_cs = m_cs;
      cycles(50); #1;
      chk("pause_frozen", count, to_bcd(saved_cs));
      rem = CLK_DIV - m_presc;
      start = 1'b1; cycles(1); start = 1'b0;
      if (rem > 1) cycles(rem - 1);
      #1;
      chk("resume_pre_tick", count, to_bcd(saved_cs));
      cycles(1); #1;
      chk("resume_tick", count, to_bcd(saved_cs + 1));

      // countdown to zero
      clr = 1'b1; cycles(1); clr = 1'b0;
      ld = 1'b1; load_data = 24'h000002; cycles(1); ld = 1'b0;
      start = 1'b1; dir = 1'b1; cycles(1); start = 1'b0;
      cycles(7); #1;
      chk("down_7", count, 24'h000001);
      chk("down_7_done", {23'd0, done}, 24'd0);
      cycles(1); #1;
      chk("down_8", count, 24'h000000);
      chk("down_8_done", {22'd0, done, running}, 24'd2);
      start = 1'b1; dir = 1'b0; cycles(1); start = 1'b0;
      cycles(10); #1;
      chk("done_start_ignored", {22'd0, done, running}, 24'd2);
      chk("done_count_zero", count, 24'h000000);

      // up to the limit
      ld = 1'b1; load_data = 24'h595998; cycles(1); ld = 1'b0;
      start = 1'b1; dir = 1'b0; cycles(1); start = 1'b0;
      cycles(4); #1;
      chk("up_lim_4", count, 24'h595999);
      chk("up_lim_4_run", {22'd0, done, running}, 24'd1);
      cycles(4); #1;
      chk("up_lim_8", {done, count}, 25'h1595999);
      cycles(8); #1;
      chk("up_lim_hold", count, 24'h595999);
      clr = 1'b1; cycles(1); clr = 1'b0;
      ld = 1'b1; load_data = 24'h7A9C9F; cycles(1); ld = 1'b0; #1;
      chk("ld_clamp", count, 24'h595999);

      // clr and lap together with a full FIFO
      clr = 1'b1; cycles(1); clr = 1'b0;
      start = 1'b1; dir = 1'b0; cycles(1); start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         lap = 1'b1; cycles(1); lap = 1'b0; cycles(2);
      end
      lap = 1'b1; clr = 1'b1; cycles(1); lap = 1'b0; clr = 1'b0; #1;
      chk("clr_lap_state", {20'd0, running, done, lap_valid, lap_ovf}, 24'd0);
      chk("clr_lap_count", count, 24'd0);

      // randomized command stream
      for (int n = 0; n < 4000; n++) begin
         start  = ($urandom_range(0, 99) < 8);
         stop   = ($urandom_range(0, 99) < 3);
         clr    = ($urandom_range(0, 99) < 1);
         ld     = ($urandom_range(0, 99) < 4);
         lap    = ($urandom_range(0, 99) < 10);
         lap_rd = ($urandom_range(0, 99) < 8);
         rst    = ($urandom_range(0, 999) < 2);
         dir    = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0: load_data = 24'($urandom());
            1: load_data = to_bcd(LAST_CS - $urandom_range(0, 9));
            2: load_data = to_bcd($urandom_range(0, 5));
            default: load_data = to_bcd($urandom_range(0, LAST_CS));
         endcase
         cycles(1);
      end
      {start, stop, clr, ld, lap, lap_rd, rst} = '0;
      cycles(2);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lap_timer.md
# lap_timer

Parametrised BCD stopwatch/countdown timer with a lap-capture FIFO; successor to the fixed two-mode digital timer. Counts mm:ss.cc up or down from a loadable start value, stops on reaching the count limit, and records lap snapshots in a FIFO for the display/readout path. It sits between the debounced button controller (single-cycle command pulses) and the 7-segment/LED display mux.

## Interface
- `CLK_DIV`, 1_000_000: `clk` cycles per centisecond tick (≥2).
- `LAP_DEPTH`, 8: lap FIFO entries (power of two, ≥2).
- `LAP_AW`, $clog2(LAP_DEPTH): FIFO address width (derived, not overridden).

- `clk` in 1: single clock.
- `rst` in 1: synchronous reset, active-high.
- `start` in 1: pulse; begin/resume counting.
- `stop` in 1: pulse; pause.
- `clr` in 1: pulse; zero count, flush FIFO, go IDLE.
- `ld` in 1: pulse; load `load_data`.
- `dir` in 1: 0 = count up, 1 = count down; sampled on `start`.
- `load_data` in 24: BCD {mH,mL,sH,sL,cH,cL}.
- `lap` in 1: pulse; push current count to FIFO.
- `lap_rd` in 1: pulse; pop FIFO head.
- `count` out 24: current BCD count.
- `running` out 1: state == RUN.
- `done` out 1: state == DONE (limit reached).
- `lap_data` out 24: FIFO head (valid when `lap_valid`).
- `lap_valid` out 1: FIFO non-empty.
- `lap_full` out 1: FIFO full.
- `lap_ovf` out 1: sticky; a lap was dropped.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
  - IDLE/PAUSE + `start` → RUN; latch `dir` into internal `dir_q`.
  - RUN + `stop` → PAUSE.
  - RUN reaching limit → DONE.
  - Any state + `clr` → IDLE.
  - DONE + `start` is ignored; only `clr` or `ld` leave DONE (`ld` → IDLE).
- Command priority in one cycle: `clr` > `ld` > `stop` > `start`.
- `ld` is accepted in IDLE, PAUSE and DONE; ignored in RUN. Load clamping is per digit: mH, sH ≤ 5; all other digits ≤ 9; an out-of-range digit loads as its maximum.
- Digit moduli: cL, cH, sL, mL wrap at 10; sH, mH wrap at 6. Carry/borrow ripples within a single cycle.
- Limits:
  - Up: at 59:59.99, the next tick holds 59:59.99 and enters DONE.
  - Down: the tick that produces 00:00.00 enters DONE.
  - Starting down from 00:00.00 enters DONE on the first tick; the count stays at zero.
- Lap:
  - Accepted in RUN and PAUSE; ignored in IDLE and DONE.
  - When full and no simultaneous pop, the push is dropped and `lap_ovf` is set. `lap_ovf` clears only on `clr` or `rst`.
  - `lap_rd` when empty is ignored.
  - Simultaneous push and pop is always legal, including when full or empty (when empty, the pushed value becomes head next cycle).
- `clr` flushes the FIFO and takes effect even mid-RUN.

## Timing
- Reset values:
  - `count` = 0; state IDLE.
  - `running`, `done`, `lap_valid`, `lap_full`, `lap_ovf` = 0.
  - `lap_data` = 0; prescaler = 0; `dir_q` = 0.
- Prescaler:
  - Counts 0..CLK_DIV-1 only in RUN; asserts internal `tick` on the cycle it equals CLK_DIV-1, then wraps to 0.
  - Held in PAUSE/DONE; zeroed on `clr`, `ld` and `rst`.
- `count` updates on the clock edge ending the `tick` cycle.
  - First increment after `start` from a zeroed prescaler: CLK_DIV cycles after the `start` edge.
  - `done` rises on the same edge as the terminal count.
- The state transition caused by a command is visible the cycle after the pulse. `running` and `done` are decoded from registered state (no combinational path from inputs).
- `ld` value appears on `count` the cycle after the pulse.
- Lap timing:
  - A lap captures the registered `count` of the pulse cycle.
  - `lap_valid`, `lap_full` and `lap_data` reflect a push or pop one cycle after the pulse.
  - `lap_data` is registered-read: the head value, zero when empty.
- A `tick` coinciding with `stop` still applies; the count advances, then PAUSE.

## Structure
- `timer_pkg`: state enum, digit-limit constants (`DIG_MAX9` = 4'd9, `DIG_MAX5` = 4'd5), 24-bit BCD time typedef, and constants `T_MAX` = 24'h595999 and `T_ZERO`.
- Sub-module `bcd_digit`:
  - Parameter `MAX`.
  - Inputs: `en`, `dn`, `ld`, `ld_val`.
  - Outputs: `q`, plus combinational `co` (carry/borrow out).
  - Six instances are chained inside `lap_timer`.
- FIFO and FSM are inline in `lap_timer`.

## Test plan
Bench uses CLK_DIV=4, LAP_DEPTH=4.
- Reset, `start` with dir=0, run 400 cycles → count = 00:01.00, `running`=1.
- `ld` 24'h000002, `start` with dir=1 → count reaches 00:00.00 at cycle 8 after start; `done`=1, `running`=0; further ticks leave count at 0; `start` is ignored.
- `ld` 24'h595998, `start` up → 59:59.99 after 4 cycles, `done` after 8, count held at 59:59.99. Also `ld` 24'h7A9C9F → loads 24'h595999.
- While running, 5 `lap` pulses 20 cycles apart → `lap_full`=1, `lap_ovf`=1, 4 entries. `lap_rd` ×4 returns ascending captures (00:00.05, 00:00.10, 00:00.15, 00:00.20 given start-aligned timing); then `lap_valid`=0.
- `stop` mid-run for 50 cycles, then `start` → count frozen during pause, prescaler phase preserved (next tick at the remaining cycle count).
- `clr` and `lap` in the same RUN cycle, FIFO full → state IDLE, count 0, FIFO empty, `lap_ovf`=0.
